// File: rtl/lsu_fault_pipe_pkg.sv
// Shared LSU fault definitions: RISC-V load/store exception causes, the staged
// fault packet shape and the capture FSM state encoding.
package lsu_fault_pipe_pkg;

    localparam int LSU_ADDR_W = 64;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_ACCESS   = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_ACCESS   = 4'd7;

    typedef struct packed {
        logic                  valid;
        logic [3:0]            cause;
        logic [LSU_ADDR_W-1:0] addr;
    } lsu_fault_pkt_t;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } cap_state_e;

    // Misaligned outranks access fault when the address check raises both.
    function automatic logic [3:0] fault_cause(input logic store, input logic misaligned);
        if (store) begin
            return misaligned ? EXC_ST_MISALIGN : EXC_ST_ACCESS;
        end
        return misaligned ? EXC_LD_MISALIGN : EXC_LD_ACCESS;
    endfunction

endpackage

// File: rtl/lsu_fault_capture.sv
// First-error capture register (mtval source) with TLU ack handshake, and a
// saturating count of reported faults.
module lsu_fault_capture
    import lsu_fault_pipe_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_l,
    input  logic              i_exc_valid,
    input  logic [3:0]        i_exc_cause,
    input  logic [ADDR_W-1:0] i_exc_addr,
    input  logic              i_ack,
    input  logic              i_cnt_clr,
    output logic              o_held_valid,
    output logic [3:0]        o_held_cause,
    output logic [ADDR_W-1:0] o_held_addr,
    output logic [CNT_W-1:0]  o_fault_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cap_state_e        r_state;
    cap_state_e        w_state_nxt;
    logic              w_load;
    logic [3:0]        r_held_cause;
    logic [ADDR_W-1:0] r_held_addr;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An ack in the same cycle as a new error frees the slot for that error;
    // without an ack the first error stays.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_exc_valid) begin
                    w_state_nxt = HELD;
                    w_load      = 1'b1;
                end
            end
            HELD: begin
                if (i_exc_valid && i_ack) begin
                    w_load = 1'b1;
                end else if (!i_exc_valid && i_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_held_cause <= '0;
            r_held_addr  <= '0;
        end else if (w_load) begin
            r_held_cause <= i_exc_cause;
            r_held_addr  <= i_exc_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_cnt <= i_exc_valid ? CNT_ONE : '0;
        end else if (i_exc_valid && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign o_held_valid = (r_state == HELD);
    assign o_held_cause = r_held_cause;
    assign o_held_addr  = r_held_addr;
    assign o_fault_cnt  = r_cnt;

endmodule

// File: rtl/lsu_fault_dffe.sv
// Enable flop with asynchronous active-low reset; the standard stage register.
module lsu_fault_dffe #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_l,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            o_dout <= '0;
        end else if (i_en) begin
            o_dout <= i_din;
        end
    end

endmodule

// File: rtl/lsu_fault_pipe.sv
// Stages DC1 address-check faults through DC2/DC3 with freeze and flush, and
// reports a registered DC3 exception packet plus the first-error capture.
module lsu_fault_pipe
    import lsu_fault_pipe_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              lsu_freeze_dc3,
    input  logic              flush_dc2,
    input  logic              flush_dc3,
    input  logic              pkt_valid_dc1,
    input  logic              pkt_dma_dc1,
    input  logic              pkt_store_dc1,
    input  logic [ADDR_W-1:0] start_addr_dc1,
    input  logic              access_fault_dc1,
    input  logic              misaligned_fault_dc1,
    output logic              exc_valid_dc3,
    output logic [3:0]        exc_cause_dc3,
    output logic [ADDR_W-1:0] exc_addr_dc3,
    output logic              held_valid,
    output logic [3:0]        held_cause,
    output logic [ADDR_W-1:0] held_addr,
    input  logic              held_ack,
    output logic [CNT_W-1:0]  fault_cnt,
    input  logic              fault_cnt_clr
);

    logic              w_adv;
    logic              w_err_dc1;
    logic [3:0]        w_cause_dc1;
    logic              r_err_dc2;
    logic [3:0]        r_cause_dc2;
    logic [ADDR_W-1:0] r_addr_dc2;
    logic              r_err_dc3;
    logic [3:0]        r_cause_dc3;
    logic [ADDR_W-1:0] r_addr_dc3;

    // DMA traffic is never reported, whatever the address check says.
    assign w_adv       = ~lsu_freeze_dc3;
    assign w_err_dc1   = pkt_valid_dc1 & ~pkt_dma_dc1 & (access_fault_dc1 | misaligned_fault_dc1);
    assign w_cause_dc1 = fault_cause(pkt_store_dc1, misaligned_fault_dc1);

    lsu_fault_dffe #(.WIDTH(1 + 4 + ADDR_W)) u_dc2 (
        .i_clk   (clk),
        .i_rst_l (rst_l),
        .i_en    (w_adv),
        .i_din   ({w_err_dc1, w_cause_dc1, start_addr_dc1}),
        .o_dout  ({r_err_dc2, r_cause_dc2, r_addr_dc2})
    );

    lsu_fault_dffe #(.WIDTH(1 + 4 + ADDR_W)) u_dc3 (
        .i_clk   (clk),
        .i_rst_l (rst_l),
        .i_en    (w_adv),
        .i_din   ({r_err_dc2 & ~flush_dc2, r_cause_dc2, r_addr_dc2}),
        .o_dout  ({r_err_dc3, r_cause_dc3, r_addr_dc3})
    );

    // A frozen DC3 keeps its contents and reports them once the freeze drops.
    assign exc_valid_dc3 = r_err_dc3 & ~flush_dc3 & ~lsu_freeze_dc3;
    assign exc_cause_dc3 = r_cause_dc3;
    assign exc_addr_dc3  = r_addr_dc3;

    lsu_fault_capture #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_capture (
        .i_clk        (clk),
        .i_rst_l      (rst_l),
        .i_exc_valid  (exc_valid_dc3),
        .i_exc_cause  (r_cause_dc3),
        .i_exc_addr   (r_addr_dc3),
        .i_ack        (held_ack),
        .i_cnt_clr    (fault_cnt_clr),
        .o_held_valid (held_valid),
        .o_held_cause (held_cause),
        .o_held_addr  (held_addr),
        .o_fault_cnt  (fault_cnt)
    );

endmodule

// File: tb/tb_lsu_fault_pipe.sv
// Bench for lsu_fault_pipe: directed scenarios plus random traffic against a
// transaction-level model compared on every falling clock edge.
module tb_lsu_fault_pipe;

    localparam int ADDR_W = 64;
    localparam int CNT_W  = 16;
    localparam int CNT_SAT = 65535;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic              lsu_freeze_dc3 = 1'b0;
    logic              flush_dc2 = 1'b0;
    logic              flush_dc3 = 1'b0;
    logic              pkt_valid_dc1 = 1'b0;
    logic              pkt_dma_dc1 = 1'b0;
    logic              pkt_store_dc1 = 1'b0;
    logic [ADDR_W-1:0] start_addr_dc1 = '0;
    logic              access_fault_dc1 = 1'b0;
    logic              misaligned_fault_dc1 = 1'b0;
    logic              held_ack = 1'b0;
    logic              fault_cnt_clr = 1'b0;
    logic              exc_valid_dc3;
    logic [3:0]        exc_cause_dc3;
    logic [ADDR_W-1:0] exc_addr_dc3;
    logic              held_valid;
    logic [3:0]        held_cause;
    logic [ADDR_W-1:0] held_addr;
    logic [CNT_W-1:0]  fault_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_fault_pipe #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .rst_l                (rst_l),
        .lsu_freeze_dc3       (lsu_freeze_dc3),
        .flush_dc2            (flush_dc2),
        .flush_dc3            (flush_dc3),
        .pkt_valid_dc1        (pkt_valid_dc1),
        .pkt_dma_dc1          (pkt_dma_dc1),
        .pkt_store_dc1        (pkt_store_dc1),
        .start_addr_dc1       (start_addr_dc1),
        .access_fault_dc1     (access_fault_dc1),
        .misaligned_fault_dc1 (misaligned_fault_dc1),
        .exc_valid_dc3        (exc_valid_dc3),
        .exc_cause_dc3        (exc_cause_dc3),
        .exc_addr_dc3         (exc_addr_dc3),
        .held_valid           (held_valid),
        .held_cause           (held_cause),
        .held_addr            (held_addr),
        .held_ack             (held_ack),
        .fault_cnt            (fault_cnt),
        .fault_cnt_clr        (fault_cnt_clr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        err;
        bit [3:0]  cause;
        bit [63:0] addr;
    } slot_t;

    slot_t     m_slot [2];   // [0] = instruction in DC2, [1] = instruction in DC3
    bit        m_hv;
    bit [3:0]  m_hc;
    bit [63:0] m_ha;
    int        m_cnt;

    // Causes 4..7: +2 for a store, +1 for an access (non-misaligned) fault.
    function automatic bit [3:0] spec_cause(bit store, bit mis);
        return 4'(4 + (store ? 2 : 0) + (mis ? 0 : 1));
    endfunction

    always @(negedge clk) begin
        bit ev;
        if (!rst_l) begin
            m_slot[0] = '{0, 0, 0};
            m_slot[1] = '{0, 0, 0};
            m_hv = 0; m_hc = 0; m_ha = 0; m_cnt = 0;
        end
        ev = rst_l && m_slot[1].err && !flush_dc3 && !lsu_freeze_dc3;
        chk("exc_valid", 64'(exc_valid_dc3), 64'(ev));
        chk("exc_cause", 64'(exc_cause_dc3), 64'(m_slot[1].cause));
        chk("exc_addr", exc_addr_dc3, m_slot[1].addr);
        chk("held_valid", 64'(held_valid), 64'(m_hv));
        chk("held_cause", 64'(held_cause), 64'(m_hc));
        chk("held_addr", held_addr, m_ha);
        chk("fault_cnt", 64'(fault_cnt), 64'(m_cnt));
        if (rst_l) begin
            if (ev) m_cnt = fault_cnt_clr ? 1 : ((m_cnt < CNT_SAT) ? m_cnt + 1 : m_cnt);
            else if (fault_cnt_clr) m_cnt = 0;
            if (ev && (!m_hv || held_ack)) begin
                m_hv = 1; m_hc = m_slot[1].cause; m_ha = m_slot[1].addr;
            end else if (!ev && held_ack) begin
                m_hv = 0;
            end
            if (!lsu_freeze_dc3) begin
                m_slot[1] = '{m_slot[0].err && !flush_dc2, m_slot[0].cause, m_slot[0].addr};
                m_slot[0] = '{pkt_valid_dc1 && !pkt_dma_dc1 && (access_fault_dc1 || misaligned_fault_dc1),
                              spec_cause(pkt_store_dc1, misaligned_fault_dc1), start_addr_dc1};
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        lsu_freeze_dc3 = 0; flush_dc2 = 0; flush_dc3 = 0;
        pkt_valid_dc1 = 0; pkt_dma_dc1 = 0; pkt_store_dc1 = 0;
        access_fault_dc1 = 0; misaligned_fault_dc1 = 0;
        start_addr_dc1 = '0; held_ack = 0; fault_cnt_clr = 0;
    endtask

    task automatic drive(input bit v, input bit dma, input bit st, input bit acc, input bit mis,
                         input logic [63:0] a);
        pkt_valid_dc1 = v; pkt_dma_dc1 = dma; pkt_store_dc1 = st;
        access_fault_dc1 = acc; misaligned_fault_dc1 = mis; start_addr_dc1 = a;
    endtask

    task automatic clear_all();
        idle_in(); tick(); tick(); tick();
        held_ack = 1; fault_cnt_clr = 1; tick();
        idle_in();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_exc_valid"}, 64'(exc_valid_dc3), 64'd0);
        chk({nm, "_exc_cause"}, 64'(exc_cause_dc3), 64'd0);
        chk({nm, "_exc_addr"}, exc_addr_dc3, 64'd0);
        chk({nm, "_held_valid"}, 64'(held_valid), 64'd0);
        chk({nm, "_held_cause"}, 64'(held_cause), 64'd0);
        chk({nm, "_held_addr"}, held_addr, 64'd0);
        chk({nm, "_fault_cnt"}, 64'(fault_cnt), 64'd0);
    endtask

    initial begin
        idle_in();
        tick(); tick();
        chk_all_zero("reset");
        rst_l = 1;

        // Load, misaligned + access: misaligned wins, cause 4, two-cycle latency.
        drive(1, 0, 0, 1, 1, 64'h0000_0000_F004_0002); tick();
        idle_in(); tick();
        chk("t1_exc_valid", 64'(exc_valid_dc3), 64'd1);
        chk("t1_exc_cause", 64'(exc_cause_dc3), 64'd4);
        chk("t1_exc_addr", exc_addr_dc3, 64'h0000_0000_F004_0002);
        tick();
        chk("t1_held_valid", 64'(held_valid), 64'd1);
        chk("t1_fault_cnt", 64'(fault_cnt), 64'd1);
        clear_all();

        // Store access fault frozen in DC2 for three cycles.
        drive(1, 0, 1, 1, 0, 64'h0000_0000_0000_A000); tick();
        idle_in(); lsu_freeze_dc3 = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_frozen_exc", 64'(exc_valid_dc3), 64'd0);
            tick();
        end
        lsu_freeze_dc3 = 0;
        #1 chk("t2_unfreeze_exc", 64'(exc_valid_dc3), 64'd0);
        tick();
        #1 chk("t2_exc_valid", 64'(exc_valid_dc3), 64'd1);
        chk("t2_exc_cause", 64'(exc_cause_dc3), 64'd7);
        tick();
        #1 chk("t2_single_pulse", 64'(exc_valid_dc3), 64'd0);
        clear_all();

        // Flush in DC2, then a second fault flushed in DC3.
        drive(1, 0, 0, 0, 1, 64'h10); tick();
        drive(1, 0, 0, 0, 1, 64'h20); flush_dc2 = 1;
        #1 chk("t3_c1_exc", 64'(exc_valid_dc3), 64'd0);
        tick();
        idle_in();
        #1 chk("t3_c2_exc", 64'(exc_valid_dc3), 64'd0);
        tick();
        flush_dc3 = 1;
        #1 chk("t3_c3_exc", 64'(exc_valid_dc3), 64'd0);
        tick();
        idle_in();
        #1 chk("t3_held_valid", 64'(held_valid), 64'd0);
        chk("t3_fault_cnt", 64'(fault_cnt), 64'd0);

        // Back-to-back faults: first wins; then ack coincident with a third fault.
        drive(1, 0, 0, 0, 1, 64'h100); tick();
        drive(1, 0, 0, 0, 1, 64'h200); tick();
        idle_in();
        #1 chk("t4_exc_addr0", exc_addr_dc3, 64'h100);
        tick();
        #1 chk("t4_exc_addr1", exc_addr_dc3, 64'h200);
        tick();
        drive(1, 0, 0, 0, 1, 64'h300);
        #1 chk("t4_held_addr", held_addr, 64'h100);
        chk("t4_held_valid", 64'(held_valid), 64'd1);
        chk("t4_fault_cnt", 64'(fault_cnt), 64'd2);
        tick();
        idle_in(); tick();
        held_ack = 1;
        #1 chk("t5_exc_addr", exc_addr_dc3, 64'h300);
        tick();
        held_ack = 0;
        #1 chk("t5_held_addr", held_addr, 64'h300);
        chk("t5_held_valid", 64'(held_valid), 64'd1);
        chk("t5_fault_cnt", 64'(fault_cnt), 64'd3);
        clear_all();

        // DMA with both flags set is never reported.
        drive(1, 1, 0, 1, 1, 64'hDEAD); tick();
        idle_in(); tick();
        #1 chk("t6_exc_valid", 64'(exc_valid_dc3), 64'd0);
        tick();
        #1 chk("t6_held_valid", 64'(held_valid), 64'd0);
        chk("t6_fault_cnt", 64'(fault_cnt), 64'd0);

        // Drive the counter into saturation.
        for (int i = 0; i < CNT_SAT + 5; i++) begin
            drive(1, 0, 1'($urandom), 1, 1'($urandom), {$urandom, $urandom});
            tick();
        end
        idle_in(); tick(); tick(); tick();
        chk("t7_fault_cnt_sat", 64'(fault_cnt), 64'hFFFF);

        // Clear coincident with a reported fault leaves a count of one.
        drive(1, 0, 0, 1, 0, 64'h40); tick();
        idle_in(); tick();
        fault_cnt_clr = 1;
        #1 chk("t8_exc_valid", 64'(exc_valid_dc3), 64'd1);
        tick();
        fault_cnt_clr = 0;
        #1 chk("t8_fault_cnt", 64'(fault_cnt), 64'd1);
        clear_all();

        // Random traffic with a reset dropped in mid-stream.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2), 1'($urandom),
                  1'($urandom), 1'($urandom), {$urandom, $urandom});
            lsu_freeze_dc3 = ($urandom_range(0, 9) < 2);
            flush_dc2      = ($urandom_range(0, 9) < 1);
            flush_dc3      = ($urandom_range(0, 9) < 1);
            held_ack       = ($urandom_range(0, 9) < 2);
            fault_cnt_clr  = ($urandom_range(0, 49) < 1);
            if (i == 1500) begin
                #1 rst_l = 0;
                #1 chk_all_zero("midrst");
                tick(); tick();
                rst_l = 1;
            end
            tick();
        end
        idle_in(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
